// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbitrates between requesters, latches one operation,
// executes it for one cycle and holds the registered response until it is consumed.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [1:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Requesters may drop valid at any time before ready; rsp_* hold until rsp_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  op_q;
    logic        id_q;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [31:0] alu_result;
    logic        alu_err;
    logic [3:0]  alu_flags;

    // On a tie, round-robin favours whoever did not win last; fixed mode favours 0.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (RR_EN && !last_grant) grant1 = 1'b1;
            else                      grant0 = 1'b1;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = rst_n && (state == S_IDLE) && grant0;
    assign req1_ready = rst_n && (state == S_IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign state_dbg  = state;

    always_comb begin
        alu_result = 32'd0;
        alu_err    = 1'b0;
        case (op_q)
            4'b0001: alu_result = a_q + b_q;
            4'b0010: alu_result = a_q - b_q;
            4'b0011: alu_result = a_q & b_q;
            4'b0100: alu_result = a_q | b_q;
            4'b1000: alu_result = a_q ^ b_q;
            4'b0111: alu_result = a_q << b_q[4:0];
            4'b1011: alu_result = a_q >> b_q[4:0];
            4'b1010: alu_result = {31'd0, a_q > b_q};
            4'b1001: alu_result = {31'd0, a_q < b_q};
            4'b0110: alu_result = {31'd0, a_q == b_q};
            4'b1100: alu_result = {31'd0, a_q != b_q};
            default: alu_err    = 1'b1;
        endcase
    end

    // Flags are produced for every opcode, including unsupported ones.
    assign alu_flags = {a_q != b_q, a_q >= b_q, a_q < b_q, a_q == b_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            op_q       <= 4'd0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_flags  <= 4'd0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q        <= grant1 ? req1_a  : req0_a;
                        b_q        <= grant1 ? req1_b  : req0_b;
                        op_q       <= grant1 ? req1_op : req0_op;
                        id_q       <= grant1;
                        last_grant <= grant1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_err    <= alu_err;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized transactions checked
// against a timeline/arithmetic reference model with an expected-response queue.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic m_last;                 // model of the last granted requester
    logic [37:0] exp_q[$];        // {id, err, flags, result}

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd8:  return a ^ b;
            4'd7:  return a << b[4:0];
            4'd11: return a >> b[4:0];
            4'd10: return (a > b) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return (a == b) ? 32'd1 : 32'd0;
            4'd12: return (a != b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [3:0] op);
        return !(op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd7, 4'd11, 4'd10, 4'd9, 4'd6, 4'd12});
    endfunction

    function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
        return {a != b, a >= b, a < b, a == b};
    endfunction

    function automatic logic [37:0] ref_rsp(input logic id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        return {id, ref_err(op), ref_flags(a, b), ref_result(op, a, b)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_quiet();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    endtask

    // One complete transaction from a lone requester; returns the captured response.
    task automatic do_txn(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, output bit ok, output logic [37:0] got);
        int n;
        ok = 1'b1;
        got = '0;
        req0_valid = (id == 1'b0); req1_valid = (id == 1'b1);
        if (id) begin req1_a = a; req1_b = b; req1_op = op; end
        else    begin req0_a = a; req0_b = b; req0_op = op; end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 10) begin tick(); n++; end
        if (n >= 10) ok = 1'b0;
        tick();
        m_last = id;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        if (n >= 10) ok = 1'b0;
        got = {rsp_id, rsp_err, rsp_flags, rsp_result};
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req0_op = 4'd1;
        req1_a = $urandom; req1_b = $urandom; req1_op = 4'd2;
        repeat (2) tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err} !== 39'd0) begin
            errors++;
            $display("FAIL reset_rsp: got %h exp 0", {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err});
        end
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 00", {req1_ready, req0_ready});
        end
        checks++;
        if (state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d exp 0", state_dbg);
        end
        drive_quiet();
        tick();
        rst_n = 1'b1;
        m_last = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        logic [37:0] exp;
        logic exp_id;
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            req0_a = $urandom; req0_b = $urandom_range(0, 40); req0_op = 4'($urandom_range(0, 15));
            req1_a = $urandom; req1_b = $urandom_range(0, 40); req1_op = 4'($urandom_range(0, 15));
            #1;
            exp_id = (k == 1);
            exp = exp_id ? ref_rsp(1'b1, req1_op, req1_a, req1_b) : ref_rsp(1'b0, req0_op, req0_a, req0_b);
            checks++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL tie_grant%0d: got %b exp %b", k, {req1_ready, req0_ready}, exp_id ? 2'b10 : 2'b01);
            end
            tick();
            m_last = exp_id;
            // Disturb the inputs after the handshake; the response must not change.
            req0_a = $urandom; req0_b = $urandom; req0_op = 4'($urandom_range(0, 15));
            req1_a = $urandom; req1_b = $urandom; req1_op = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL tie_rsp%0d: got %h exp %h", k, {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}, {1'b1, exp});
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_single();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0010;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b exp 01", {req1_ready, req0_ready});
        end
        tick();
        m_last = 1'b0;
        req0_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: rsp_valid got %b exp 0 one cycle after handshake", rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b1, 1'b0, 1'b0, 4'b1100, 32'd2}) begin
            errors++;
            $display("FAIL single_rsp: got v=%b id=%b err=%b fl=%b res=%h exp v=1 id=0 err=0 fl=1100 res=2",
                     rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, state_dbg} !== 3'b000) begin
            errors++;
            $display("FAIL single_done: got v=%b st=%0d exp v=0 st=0", rsp_valid, state_dbg);
        end
    endtask

    task automatic test_backpressure();
        logic [37:0] exp;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom_range(0, 31); req1_op = 4'b0111;
        exp = ref_rsp(1'b1, req1_op, req1_a, req1_b);
        #1;
        tick();
        m_last = 1'b1;
        req1_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
            req0_a = $urandom; req1_a = $urandom;
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result, req1_ready, req0_ready} !== {1'b1, exp, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h exp %h", c,
                         {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result, req1_ready, req0_ready}, {1'b1, exp, 2'b00});
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, state_dbg} !== 3'b000) begin
            errors++;
            $display("FAIL bp_release: got v=%b st=%0d exp v=0 st=0", rsp_valid, state_dbg);
        end
    endtask

    task automatic test_edge_ops();
        logic [31:0] ta[3];
        logic [31:0] tb[3];
        logic [3:0]  top[3];
        logic [37:0] texp[3];
        logic [37:0] got;
        bit ok;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd1;    top[0] = 4'b0001; texp[0] = {1'b0, 1'b0, 4'b1100, 32'd0};
        ta[1] = 32'd1;         tb[1] = 32'h21;   top[1] = 4'b0111; texp[1] = {1'b0, 1'b0, 4'b1010, 32'd2};
        ta[2] = 32'd7;         tb[2] = 32'd7;    top[2] = 4'b1111; texp[2] = {1'b0, 1'b1, 4'b0101, 32'd0};
        for (int k = 0; k < 3; k++) begin
            do_txn(1'b0, ta[k], tb[k], top[k], ok, got);
            checks++;
            if (!ok || got !== texp[k]) begin
                errors++;
                $display("FAIL edge_op%0d: got %h (ok=%0d) exp %h", k, got, ok, texp[k]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [37:0] got;
        logic [37:0] exp;
        bit ok;
        int seen;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_op = 4'b0001;
        #1;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req1_ready, req0_ready, state_dbg} !== 43'd0) begin
            errors++;
            $display("FAIL midrst_zero: got %h exp 0",
                     {rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, req1_ready, req0_ready, state_dbg});
        end
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        m_last = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_norsp: got %0d cycles with rsp_valid exp 0", seen);
        end
        exp = ref_rsp(1'b1, 4'b1000, 32'hDEAD_BEEF, 32'h1234_5678);
        do_txn(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1000, ok, got);
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL midrst_next: got %h (ok=%0d) exp %h", got, ok, exp);
        end
    endtask

    task automatic test_random();
        logic g;
        logic [37:0] exp;
        int d;
        for (int i = 0; i < 60; i++) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a = $urandom; req1_b = $urandom_range(0, 63);
            req0_op = 4'($urandom_range(0, 15)); req1_op = 4'($urandom_range(0, 15));
            #1;
            if (!req0_valid && !req1_valid) begin
                checks++;
                if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
                    errors++;
                    $display("FAIL rand_idle%0d: got %b exp 000", i, {req1_ready, req0_ready, rsp_valid});
                end
                tick();
                continue;
            end
            g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            exp_q.push_back(g ? ref_rsp(1'b1, req1_op, req1_a, req1_b) : ref_rsp(1'b0, req0_op, req0_a, req0_b));
            checks++;
            if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rand_grant%0d: got %b exp %b", i, {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
            end
            tick();
            m_last = g;
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_a = $urandom; req1_a = $urandom; req0_op = 4'($urandom_range(0, 15));
            #1;
            checks++;
            if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
                errors++;
                $display("FAIL rand_exec%0d: got %b exp 000", i, {req1_ready, req0_ready, rsp_valid});
            end
            tick();
            exp = exp_q.pop_front();
            d = $urandom_range(0, 3);
            for (int c = 0; c <= d; c++) begin
                checks++;
                if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result} !== {1'b1, exp}) begin
                    errors++;
                    $display("FAIL rand_rsp%0d: got %h exp %h", i, {rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_result}, {1'b1, exp});
                end
                if (c < d) tick();
            end
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_quiet();
        m_last = 1'b1;
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_edge_ops();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
